// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect and the memory responder.
// hready is the bus-level ready fed back by the interconnect. The slave
// drives hreadyout, hresp and hrdata.
interface ahb_mem_slave_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  hsel;
  logic [HADDR_SIZE-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [HDATA_SIZE-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [HDATA_SIZE-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite memory responder backed by 2**MEM_SIZE words.
// - Adds WAIT_STATES wait cycles, with hreadyout held low, before each OKAY data phase.
// - Signals illegal accesses with the two-cycle ERROR response.
// - Optional macro AHB_MEM_PROT_EN: a write with hprot[1]=0 (user access) is answered
//   with ERROR and is not committed. When the macro is not defined, hprot is ignored.
// - Data is little-endian across 4 byte lanes (HDATA_SIZE is fixed at 32).
module ahb_mem_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_SIZE    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb_mem_slave_if.slave bus
);
  localparam int WORDS = 2 ** MEM_SIZE;
  localparam int HI_W  = HADDR_SIZE - MEM_SIZE - 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_OKAY = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t                state_r;
  logic [3:0]            cnt_r;
  logic [MEM_SIZE-1:0]   idx_r;
  logic [3:0]            be_r;
  logic                  write_r;
  logic                  hreadyout_r;
  logic                  hresp_r;
  logic [HDATA_SIZE-1:0] hrdata_r;
  logic [HDATA_SIZE-1:0] mem_r [WORDS];

  logic                  open_s;
  logic                  accept_s;
  logic                  req_err_s;
  logic                  commit_s;
  logic [3:0]            be_s;
  logic [MEM_SIZE-1:0]   req_idx_s;
  logic [MEM_SIZE-1:0]   rd_idx_s;
  logic [HDATA_SIZE-1:0] wr_word_s;
  logic [HDATA_SIZE-1:0] rd_word_s;
  logic                  unused_s;

  // Illegal size, misaligned access, or address beyond the array.
  function automatic logic addr_err(input logic [HADDR_SIZE-1:0] a, input logic [2:0] sz);
    logic e;
    case (sz)
      3'd0:    e = 1'b0;
      3'd1:    e = a[0];
      3'd2:    e = (a[1:0] != 2'b00);
      default: e = 1'b1;
    endcase
    e = e | (a[HADDR_SIZE-1:MEM_SIZE+2] != {HI_W{1'b0}});
    return e;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] ofs, input logic [2:0] sz);
    logic [3:0] m;
    case (sz)
      3'd0:    m = 4'b0001 << ofs;
      3'd1:    m = ofs[1] ? 4'b1100 : 4'b0011;
      3'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replace the enabled byte lanes of the old word with the new data.
  function automatic logic [HDATA_SIZE-1:0] merge_lanes(input logic [HDATA_SIZE-1:0] old_w,
                                                        input logic [HDATA_SIZE-1:0] new_w,
                                                        input logic [3:0]            be);
    logic [HDATA_SIZE-1:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        m[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        m[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return m;
  endfunction

  // Decode the address phase on the bus. Accepts are only taken in states that drive hreadyout high.
  always_comb begin
    open_s    = (state_r == ST_IDLE) || (state_r == ST_OKAY) || (state_r == ST_ERR2);
    accept_s  = open_s & bus.hsel & bus.hready & bus.htrans[1];
    req_idx_s = bus.haddr[MEM_SIZE+1:2];
    be_s      = lane_mask(bus.haddr[1:0], bus.hsize);
`ifdef AHB_MEM_PROT_EN
    req_err_s = addr_err(bus.haddr, bus.hsize) | (bus.hwrite & ~bus.hprot[1]);
`else
    req_err_s = addr_err(bus.haddr, bus.hsize);
`endif
  end

  // Write merge and read-word select. A read accepted during a write's OKAY cycle sees the new data.
  always_comb begin
    commit_s  = (state_r == ST_OKAY) & write_r;
    wr_word_s = merge_lanes(mem_r[idx_r], bus.hwdata, be_r);
    if (accept_s) begin
      rd_idx_s = req_idx_s;
    end else begin
      rd_idx_s = idx_r;
    end
    if (commit_s && (rd_idx_s == idx_r)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
  end

  // Transfer sequencing FSM with registered hreadyout/hresp/hrdata.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      idx_r       <= {MEM_SIZE{1'b0}};
      be_r        <= 4'b0000;
      write_r     <= 1'b0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      hrdata_r    <= {HDATA_SIZE{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_OKAY, ST_ERR2: begin
          if (accept_s) begin
            idx_r   <= req_idx_s;
            be_r    <= be_s;
            write_r <= bus.hwrite;
            if (req_err_s) begin
              state_r     <= ST_ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_r     <= ST_OKAY;
              hreadyout_r <= 1'b1;
              hresp_r     <= 1'b0;
              if (!bus.hwrite) begin
                hrdata_r <= rd_word_s;
              end
            end else begin
              state_r     <= ST_WAIT;
              cnt_r       <= 4'(WAIT_STATES - 1);
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b0;
            end
          end else begin
            state_r     <= ST_IDLE;
            write_r     <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= ST_OKAY;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            if (!write_r) begin
              hrdata_r <= rd_word_s;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ERR1: begin
          state_r     <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
        end
      endcase
    end
  end

  // Word array. Reset clears it. It is written only when an OKAY write data phase closes.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_r[i] <= {HDATA_SIZE{1'b0}};
      end
    end else if (commit_s) begin
      mem_r[idx_r] <= wr_word_s;
    end
  end

  assign bus.hreadyout = hreadyout_r;
  assign bus.hresp     = hresp_r;
  assign bus.hrdata    = hrdata_r;

  // Burst type is not needed: every beat is decoded on its own.
  assign unused_s = ^{bus.hburst, bus.hprot};
endmodule
